path_delay_probe: RTL and testbench
===================================

# path_delay_probe

Measurement controller for chained delay paths: drives the path input with a clean edge, senses the asynchronous path output through a synchronizer, and counts clock cycles until the edge arrives. It repeats this for 2^TRIALS_LOG2 trials and reports the accumulated cycle count. One instance sits beside each instantiated delay chain, with path_drive wired to the chain's pathInput and path_sense wired from its pathResult. Readout logic consumes delay_sum on the done pulse.

## Interface
- CNT_W, 16, width of per-trial cycle counter and of timeout limit
- TRIALS_LOG2, 3, log2 of trials per measurement (8 trials)
- SYNC_STAGES, 2, flops in path_sense synchronizer (≥2)
- SETTLE_CYC, 32, cycles path must read steady before each launch
- TIMEOUT_CYC, 4096, max cycles per SETTLE or WAIT phase (< 2^CNT_W)
- PATH_INV, 0, 1 if chain inverts overall (chain of even inverting stages → 0)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a measurement; sampled only in IDLE
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at end of measurement (success or timeout)
- timeout  out  1  sticky error flag, valid with done, cleared on next accepted start
- delay_sum  out  CNT_W+TRIALS_LOG2  sum of per-trial counts, valid with done, held until next start
- path_drive  out  1  edge source to path input, registered
- path_sense  in  1  path output, asynchronous to clk

## Operation
- States: IDLE, SETTLE, LAUNCH, WAIT, FINISH.
- IDLE: on start=1 → SETTLE; clear delay_sum, trial index, timeout; busy=1 next cycle.
- SETTLE: hold path_drive; count cycles where synced sense == path_drive^PATH_INV, reset count on mismatch; after SETTLE_CYC consecutive matches → LAUNCH. Phase timer reaching TIMEOUT_CYC → timeout=1, FINISH.
- LAUNCH: one cycle; toggle path_drive; clear trial counter to 0 → WAIT.
- WAIT: trial counter +1 per cycle; when synced sense == new path_drive^PATH_INV, add (counter+1) to delay_sum, increment trial index; last trial → FINISH, else → SETTLE. Counter reaching TIMEOUT_CYC → timeout=1, FINISH; delay_sum holds partial sum.
- FINISH: done=1 for one cycle, busy=0 → IDLE.
- path_drive alternates polarity every trial; never reset mid-measurement except by rst_n.
- Arithmetic: unsigned; delay_sum width prevents overflow (TRIALS × (2^CNT_W−1) fits).

## Timing
- Reset values: busy=0, done=0, timeout=0, delay_sum=0, path_drive=0, synchronizer flops=0, state=IDLE.
- Per-trial count definition: clock edges from the path_drive toggle to the edge at which WAIT registers the match. A zero-delay path measures exactly SYNC_STAGES+1 (3 by default).
- start in the same cycle as done, or while busy: ignored.
- Reset mid-measurement: immediate return to reset values; no done pulse.
- A glitch on path_sense during WAIT that returns to the old value before synchronization: not counted. The first synced match ends the trial.
- Latency start→done (zero-delay path, no timeout): 1 + TRIALS×(SETTLE_CYC + 1 + SYNC_STAGES+1) + 1 cycles.

## Structure
- Shared package: state enum, default parameter constants, function computing delay_sum width.
- Sub-module probe_sync: SYNC_STAGES-deep flop chain with rst_n async clear, marked to keep and place flops adjacent.
- The FSM, counters, and accumulator live in path_delay_probe.

## Test plan
- path_sense = path_drive combinationally, defaults, start pulse → done after 8 trials, delay_sum=24, timeout=0, path_drive ends at 0.
- path_sense = path_drive through 5-cycle register delay → each trial 8, delay_sum=64.
- path_sense stuck 0 → trial 0 settles, WAIT times out after TIMEOUT_CYC: timeout=1, done pulse, delay_sum=0.
- PATH_INV=1 with path_sense = ~path_drive → delay_sum=24; with non-inverted loop → SETTLE timeout, timeout=1.
- start held high through busy → exactly one measurement; a second start in the cycle after done → new measurement, timeout cleared.
- rst_n asserted during WAIT of trial 3 → all outputs at reset values the same cycle, no done. A following start yields delay_sum=24.

Source files
------------

// File: rtl/path_delay_probe_pkg.sv
// Shared types and defaults for the path delay probe.
// The accumulator is sized so that every trial can hit the counter limit without overflowing.
package path_delay_probe_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_TRIALS_LOG2 = 3;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_SETTLE_CYC  = 32;
   localparam int DEF_TIMEOUT_CYC = 4096;
   localparam int DEF_PATH_INV    = 0;

   function automatic int sum_width(input int cnt_w, input int trials_log2);
      return cnt_w + trials_log2;
   endfunction

endpackage

// File: rtl/path_delay_probe_sync.sv
// Multi-flop synchronizer for the asynchronous path output.
// The flops are kept and grouped so the tools treat them as one synchronizer.
module probe_sync
#(
   parameter int STAGES = 2
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   (* async_reg = "true", keep = "true" *) logic [STAGES-1:0] r_sync;

   // shift the sampled path output through the synchronizer chain
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/path_delay_probe.sv
// Delay-path measurement controller: launches edges into a chain, times their arrival
// through a synchronizer and accumulates the cycle counts over 2^TRIALS_LOG2 trials.
module path_delay_probe
   import path_delay_probe_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TRIALS_LOG2 = DEF_TRIALS_LOG2,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int PATH_INV    = DEF_PATH_INV
)(
   input  logic                                          i_clk,
   input  logic                                          i_rst_n,
   input  logic                                          i_start,
   output logic                                          o_busy,
   output logic                                          o_done,
   output logic                                          o_timeout,
   output logic [sum_width(CNT_W, TRIALS_LOG2)-1:0]      o_delay_sum,
   output logic                                          o_path_drive,
   input  logic                                          i_path_sense
);

   localparam int SUM_W  = sum_width(CNT_W, TRIALS_LOG2);
   localparam int TRL_W  = TRIALS_LOG2 + 1;
   localparam int TRIALS = 1 << TRIALS_LOG2;
   localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SETTLE_CYC - 1);
   localparam logic [TRL_W-1:0] TRIAL_LAST = TRL_W'(TRIALS - 1);
   localparam logic             INV        = 1'(PATH_INV);

   state_e             r_state,     w_state_nxt;
   logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
   logic [CNT_W-1:0]   r_match_cnt, w_match_cnt_nxt;
   logic [TRL_W-1:0]   r_trial,     w_trial_nxt;
   logic [SUM_W-1:0]   r_sum,       w_sum_nxt;
   logic               r_drive,     w_drive_nxt;
   logic               r_timeout,   w_timeout_nxt;
   logic               r_busy,      w_busy_nxt;
   logic               r_done,      w_done_nxt;
   logic               w_sense_sync;
   logic               w_match;
   logic [CNT_W-1:0]   w_cnt_inc;

   probe_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_path_sense),
      .o_q     (w_sense_sync)
   );

   assign w_match   = (w_sense_sync == (r_drive ^ INV));
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state, counter and accumulator decisions
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_match_cnt_nxt = r_match_cnt;
      w_trial_nxt     = r_trial;
      w_sum_nxt       = r_sum;
      w_drive_nxt     = r_drive;
      w_timeout_nxt   = r_timeout;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt     = ST_SETTLE;
               w_cnt_nxt       = '0;
               w_match_cnt_nxt = '0;
               w_trial_nxt     = '0;
               w_sum_nxt       = '0;
               w_timeout_nxt   = 1'b0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (w_match && (r_match_cnt == SET_LAST)) begin
               w_state_nxt = ST_LAUNCH;
            end else if (w_cnt_inc == TMO_LIM) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = ST_FINISH;
            end else begin
               w_cnt_nxt       = w_cnt_inc;
               w_match_cnt_nxt = w_match ? (r_match_cnt + CNT_W'(1)) : '0;
            end
         end
         ST_LAUNCH: begin
            w_drive_nxt = ~r_drive;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // r_cnt lags the edge count by one, hence the +1 on the accumulated value
            if (w_match) begin
               w_sum_nxt   = r_sum + SUM_W'(r_cnt) + SUM_W'(1);
               w_trial_nxt = r_trial + TRL_W'(1);
               if (r_trial == TRIAL_LAST) begin
                  w_state_nxt = ST_FINISH;
               end else begin
                  w_state_nxt     = ST_SETTLE;
                  w_cnt_nxt       = '0;
                  w_match_cnt_nxt = '0;
               end
            end else if (w_cnt_inc == TMO_LIM) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = ST_FINISH;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         ST_FINISH: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_LAUNCH) ||
                   (w_state_nxt == ST_WAIT);
      w_done_nxt = (w_state_nxt == ST_FINISH);
   end

   // datapath and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt       <= '0;
         r_match_cnt <= '0;
         r_trial     <= '0;
         r_sum       <= '0;
         r_drive     <= 1'b0;
         r_timeout   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_trial     <= w_trial_nxt;
         r_sum       <= w_sum_nxt;
         r_drive     <= w_drive_nxt;
         r_timeout   <= w_timeout_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_timeout    = r_timeout;
   assign o_delay_sum  = r_sum;
   assign o_path_drive = r_drive;

endmodule

// File: tb/tb_path_delay_probe.sv
// Directed bench for path_delay_probe: one non-inverting and one inverting instance
// with loopback paths selected by the stimulus.
module tb_path_delay_probe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic [1:0]  sel0 = 2'd0;
   logic        sel1 = 1'b0;
   logic [4:0]  dly = 5'd0;

   logic        busy0, done0, to0, drive0, sense0;
   logic        busy1, done1, to1, drive1, sense1;
   logic [18:0] sum0, sum1;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   // five-register delay line used as a slow path
   always @(posedge clk) dly <= {dly[3:0], drive0};

   assign sense0 = (sel0 == 2'd0) ? drive0 : (sel0 == 2'd1) ? dly[4] : 1'b0;
   assign sense1 = sel1 ? drive1 : ~drive1;

   path_delay_probe u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start0),
      .o_busy(busy0), .o_done(done0), .o_timeout(to0),
      .o_delay_sum(sum0), .o_path_drive(drive0), .i_path_sense(sense0)
   );

   path_delay_probe #(.PATH_INV(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
      .o_busy(busy1), .o_done(done1), .o_timeout(to1),
      .o_delay_sum(sum1), .o_path_drive(drive1), .i_path_sense(sense1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse_start(input int which);
      if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      if (which == 0) start0 = 1'b0; else start1 = 1'b0;
   endtask

   // wait for done, then check results and that done lasts a single cycle
   task automatic measure(input int which, input int limit, input int exp_sum,
                          input int exp_to, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((which == 0) ? done0 : done1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         chk({tag, "_done_seen"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_sum"}, (which == 0) ? 32'(sum0) : 32'(sum1), 32'(exp_sum));
         chk({tag, "_timeout"}, (which == 0) ? 32'(to0) : 32'(to1), 32'(exp_to));
         chk({tag, "_busy_at_done"}, (which == 0) ? 32'(busy0) : 32'(busy1), 32'd0);
         @(negedge clk);
         chk({tag, "_done_1cyc"}, (which == 0) ? 32'(done0) : 32'(done1), 32'd0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_timeout", 32'(to0), 32'd0);
      chk("rst_sum", 32'(sum0), 32'd0);
      chk("rst_drive", 32'(drive0), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // zero-delay loopback: 8 trials of 3
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("comb_busy_next", 32'(busy0), 32'd1);
      measure(0, 1000, 24, 0, "comb");
      chk("comb_drive_end", 32'(drive0), 32'd0);

      // five-cycle register path: 8 trials of 8
      sel0 = 2'd1;
      repeat (8) @(negedge clk);
      pulse_start(0);
      measure(0, 1000, 64, 0, "dly5");
      sel0 = 2'd0;
      repeat (4) @(negedge clk);

      // start held high through the whole measurement
      start0 = 1'b1;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done0) begin
               seen = 1'b1;
               break;
            end
         end
         start0 = 1'b0;
         chk("held_done_seen", 32'(seen), 32'd1);
         chk("held_sum", 32'(sum0), 32'd24);
      end
      repeat (3) @(negedge clk);
      chk("held_single_busy", 32'(busy0), 32'd0);

      // reset during WAIT of trial 3
      pulse_start(0);
      repeat (141) @(negedge clk);
      chk("midrst_busy_before", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy0), 32'd0);
      chk("midrst_done", 32'(done0), 32'd0);
      chk("midrst_timeout", 32'(to0), 32'd0);
      chk("midrst_sum", 32'(sum0), 32'd0);
      chk("midrst_drive", 32'(drive0), 32'd0);
      repeat (3) @(negedge clk);
      chk("midrst_no_done", 32'(done0), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      pulse_start(0);
      measure(0, 1000, 24, 0, "after_rst");

      // inverting chain, correctly inverted loop
      pulse_start(1);
      measure(1, 1000, 24, 0, "inv");

      // inverting instance with a non-inverting loop never settles; restart right after done
      sel1 = 1'b1;
      repeat (2) @(negedge clk);
      pulse_start(1);
      measure(1, 6000, 0, 1, "inv_settle_to");
      sel1 = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("restart_busy", 32'(busy1), 32'd1);
      chk("restart_to_clr", 32'(to1), 32'd0);
      measure(1, 1000, 24, 0, "restart");

      // stuck-low path: trial 0 launches, WAIT times out
      sel0 = 2'd2;
      repeat (2) @(negedge clk);
      pulse_start(0);
      measure(0, 6000, 0, 1, "stuck");
      chk("stuck_drive", 32'(drive0), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
